// File: rtl/hazard_control_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// sequencer state encoding, flush-counter width and the x0 register index.
package hazard_control_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_SLEEP = 1'b1
  } state_t;

  // Wide enough for REDIRECT_FLUSH values 1..7.
  localparam int FLUSH_CNT_W = 3;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_control_match.sv
// Combinational rs/rd comparator for one producing stage. A producer only
// matches when it is valid and writes a register other than x0.
module hazard_match
  import hazard_control_pkg::*;
(
  input  logic       i_valid,
  input  logic [4:0] i_rd,
  input  logic       i_uses_rs1,
  input  logic [4:0] i_rs1,
  input  logic       i_uses_rs2,
  input  logic [4:0] i_rs2,
  output logic       o_match
);

  logic w_rd_live;
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rd_live = i_valid && (i_rd != REG_X0);
  assign w_rs1_hit = i_uses_rs1 && (i_rs1 == i_rd);
  assign w_rs2_hit = i_uses_rs2 && (i_rs2 == i_rd);
  assign o_match   = w_rd_live && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/hazard_control.sv
// Five-stage pipeline sequencer: stalls, squashes, redirect flush and WFI sleep.
// Optional HAZARD_BYPASS_EN: with full bypassing only load-use hazards stall.
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int REDIRECT_FLUSH = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uses_rs1,
  input  logic       uses_rs2,
  input  logic [4:0] rs1_address,
  input  logic [4:0] rs2_address,
  input  logic       ex_valid,
  input  logic       ex_load,
  input  logic [4:0] ex_rd_address,
  input  logic       mem_valid,
  input  logic [4:0] mem_rd_address,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd_address,
  input  logic       branch_taken,
  input  logic       mem_busy,
  input  logic       trap,
  input  logic       mret,
  input  logic       wfi,
  input  logic       interrupt_pending,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       stall_execute,
  output logic       stall_memory,
  output logic       invalidate_fetch,
  output logic       invalidate_decode,
  output logic       invalidate_execute,
  output logic       sleeping
);

  localparam logic [FLUSH_CNT_W-1:0] LP_FLUSH_LOAD = FLUSH_CNT_W'(REDIRECT_FLUSH);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt;
  logic [FLUSH_CNT_W-1:0] w_flush_cnt_nxt;

  logic w_ex_match;
  logic w_mem_match;
  logic w_wb_match;
  logic w_data_hazard;
  logic w_trap_redirect;
  logic w_branch_redirect;

  hazard_match u_match_ex (
    .i_valid    (ex_valid),
    .i_rd       (ex_rd_address),
    .i_uses_rs1 (uses_rs1),
    .i_rs1      (rs1_address),
    .i_uses_rs2 (uses_rs2),
    .i_rs2      (rs2_address),
    .o_match    (w_ex_match)
  );

  hazard_match u_match_mem (
    .i_valid    (mem_valid),
    .i_rd       (mem_rd_address),
    .i_uses_rs1 (uses_rs1),
    .i_rs1      (rs1_address),
    .i_uses_rs2 (uses_rs2),
    .i_rs2      (rs2_address),
    .o_match    (w_mem_match)
  );

  hazard_match u_match_wb (
    .i_valid    (wb_valid),
    .i_rd       (wb_rd_address),
    .i_uses_rs1 (uses_rs1),
    .i_rs1      (rs1_address),
    .i_uses_rs2 (uses_rs2),
    .i_rs2      (rs2_address),
    .o_match    (w_wb_match)
  );

`ifdef HAZARD_BYPASS_EN
  logic w_unused_match;
  assign w_unused_match = w_mem_match | w_wb_match;
  assign w_data_hazard  = ex_load && w_ex_match;
`else
  // Without bypassing any in-flight producer blocks decode, loads included.
  logic w_unused_ex_load;
  assign w_unused_ex_load = ex_load;
  assign w_data_hazard    = w_ex_match || w_mem_match || w_wb_match;
`endif

  assign w_trap_redirect   = trap || mret;
  assign w_branch_redirect = (r_state == ST_RUN) && !mem_busy && branch_taken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (wfi && !mem_busy && !trap) w_state_nxt = ST_SLEEP;
      ST_SLEEP: if (interrupt_pending) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase

    // Redirects restart the count; otherwise it only advances while fetch moves.
    w_flush_cnt_nxt = r_flush_cnt;
    if (w_trap_redirect || w_branch_redirect) begin
      w_flush_cnt_nxt = LP_FLUSH_LOAD;
    end else if (!stall_fetch && (r_flush_cnt != '0)) begin
      w_flush_cnt_nxt = r_flush_cnt - 1'b1;
    end
  end

  always_comb begin
    stall_fetch        = 1'b0;
    stall_decode       = 1'b0;
    stall_execute      = 1'b0;
    stall_memory       = 1'b0;
    invalidate_fetch   = 1'b0;
    invalidate_decode  = 1'b0;
    invalidate_execute = 1'b0;
    sleeping           = reset_n && (r_state == ST_SLEEP);
    if (!reset_n) begin
      sleeping = 1'b0;
    end else if (w_trap_redirect) begin
      invalidate_fetch   = 1'b1;
      invalidate_decode  = 1'b1;
      invalidate_execute = 1'b1;
    end else if (r_state == ST_SLEEP) begin
      stall_fetch        = 1'b1;
      stall_decode       = 1'b1;
      stall_execute      = 1'b1;
      invalidate_execute = 1'b1;
    end else if (mem_busy) begin
      stall_fetch   = 1'b1;
      stall_decode  = 1'b1;
      stall_execute = 1'b1;
      stall_memory  = 1'b1;
    end else if (branch_taken) begin
      invalidate_fetch  = 1'b1;
      invalidate_decode = 1'b1;
    end else if (w_data_hazard) begin
      stall_fetch       = 1'b1;
      invalidate_decode = 1'b1;
    end else begin
      invalidate_fetch = (r_flush_cnt != '0);
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control (REDIRECT_FLUSH=3); honours HAZARD_BYPASS_EN
// when choosing the expected response to non-load RAW matches.
module tb_hazard_control;

  // Output vector bit order: sf sd se sm if id ie sleeping
  localparam logic [7:0] O_NONE  = 8'h00;
  localparam logic [7:0] O_LU    = 8'h84;
  localparam logic [7:0] O_BR    = 8'h0C;
  localparam logic [7:0] O_IF    = 8'h08;
  localparam logic [7:0] O_TRAP  = 8'h0E;
  localparam logic [7:0] O_BUSY  = 8'hF0;
  localparam logic [7:0] O_SLEEP = 8'hE3;
`ifdef HAZARD_BYPASS_EN
  localparam logic [7:0] O_RAW = O_NONE;
`else
  localparam logic [7:0] O_RAW = O_LU;
`endif

  logic       clk;
  logic       reset_n;
  logic       uses_rs1, uses_rs2;
  logic [4:0] rs1_address, rs2_address;
  logic       ex_valid, ex_load;
  logic [4:0] ex_rd_address;
  logic       mem_valid;
  logic [4:0] mem_rd_address;
  logic       wb_valid;
  logic [4:0] wb_rd_address;
  logic       branch_taken, mem_busy, trap, mret, wfi, interrupt_pending;
  logic       stall_fetch, stall_decode, stall_execute, stall_memory;
  logic       invalidate_fetch, invalidate_decode, invalidate_execute, sleeping;
  logic [7:0] w_outs;

  int n_total = 0;
  int n_bad   = 0;

  hazard_control #(.REDIRECT_FLUSH(3)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .uses_rs1           (uses_rs1),
    .uses_rs2           (uses_rs2),
    .rs1_address        (rs1_address),
    .rs2_address        (rs2_address),
    .ex_valid           (ex_valid),
    .ex_load            (ex_load),
    .ex_rd_address      (ex_rd_address),
    .mem_valid          (mem_valid),
    .mem_rd_address     (mem_rd_address),
    .wb_valid           (wb_valid),
    .wb_rd_address      (wb_rd_address),
    .branch_taken       (branch_taken),
    .mem_busy           (mem_busy),
    .trap               (trap),
    .mret               (mret),
    .wfi                (wfi),
    .interrupt_pending  (interrupt_pending),
    .stall_fetch        (stall_fetch),
    .stall_decode       (stall_decode),
    .stall_execute      (stall_execute),
    .stall_memory       (stall_memory),
    .invalidate_fetch   (invalidate_fetch),
    .invalidate_decode  (invalidate_decode),
    .invalidate_execute (invalidate_execute),
    .sleeping           (sleeping)
  );

  assign w_outs = {stall_fetch, stall_decode, stall_execute, stall_memory,
                   invalidate_fetch, invalidate_decode, invalidate_execute, sleeping};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%02h want=%02h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    uses_rs1 = 0; uses_rs2 = 0; rs1_address = 0; rs2_address = 0;
    ex_valid = 0; ex_load = 0; ex_rd_address = 0;
    mem_valid = 0; mem_rd_address = 0; wb_valid = 0; wb_rd_address = 0;
    branch_taken = 0; mem_busy = 0; trap = 0; mret = 0; wfi = 0;
    interrupt_pending = 0;
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_outs(input string tag, input logic [7:0] exp);
    #1;
    check_eq(tag, w_outs, exp);
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    #3;
    expect_outs("reset", O_NONE);
    next_cycle();
    reset_n = 1;
    next_cycle();
    expect_outs("idle", O_NONE);

    // Load-use on rs1, then the bubble has been inserted
    next_cycle();
    ex_valid = 1; ex_load = 1; ex_rd_address = 5'd5; uses_rs1 = 1; rs1_address = 5'd5;
    expect_outs("lu_rs1", O_LU);
    next_cycle();
    clear_inputs();
    expect_outs("lu_after", O_NONE);

    // x0 never matches
    next_cycle();
    ex_valid = 1; ex_load = 1; ex_rd_address = 5'd0; uses_rs1 = 1; rs1_address = 5'd0;
    expect_outs("lu_x0", O_NONE);

    // Load-use via rs2, and producer-valid qualification
    next_cycle();
    clear_inputs();
    ex_valid = 1; ex_load = 1; ex_rd_address = 5'd9; uses_rs2 = 1; rs2_address = 5'd9;
    expect_outs("lu_rs2", O_LU);
    next_cycle();
    ex_valid = 0;
    expect_outs("lu_invalid_ex", O_NONE);

    // Single branch: 1 + 3 cycles of fetch invalidation
    next_cycle();
    clear_inputs();
    branch_taken = 1;
    expect_outs("br", O_BR);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      clear_inputs();
      expect_outs("br_flush", O_IF);
    end
    next_cycle();
    expect_outs("br_done", O_NONE);

    // Second branch at cycle 2 restarts the count
    next_cycle();
    branch_taken = 1;
    expect_outs("br2_a", O_BR);
    next_cycle();
    branch_taken = 0;
    expect_outs("br2_c1", O_IF);
    next_cycle();
    branch_taken = 1;
    expect_outs("br2_b", O_BR);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      branch_taken = 0;
      expect_outs("br2_flush", O_IF);
    end
    next_cycle();
    expect_outs("br2_done", O_NONE);

    // Counter holds while memory is busy
    next_cycle();
    branch_taken = 1;
    expect_outs("hold_br", O_BR);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      branch_taken = 0; mem_busy = 1;
      expect_outs("hold_busy", O_BUSY);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mem_busy = 0;
      expect_outs("hold_flush", O_IF);
    end
    next_cycle();
    expect_outs("hold_done", O_NONE);

    // Branch held under 4 busy cycles, acted on in cycle 5
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      branch_taken = 1; mem_busy = 1;
      expect_outs("busy_br", O_BUSY);
    end
    next_cycle();
    mem_busy = 0;
    expect_outs("busy_br_go", O_BR);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      branch_taken = 0;
      expect_outs("busy_br_flush", O_IF);
    end
    next_cycle();
    expect_outs("busy_br_done", O_NONE);

    // Trap beats mem_busy; mret also flushes
    next_cycle();
    trap = 1; mem_busy = 1;
    expect_outs("trap_busy", O_TRAP);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      clear_inputs();
      expect_outs("trap_flush", O_IF);
    end
    next_cycle();
    expect_outs("trap_done", O_NONE);
    next_cycle();
    mret = 1;
    expect_outs("mret", O_TRAP);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mret = 0;
      expect_outs("mret_flush", O_IF);
    end
    next_cycle();
    expect_outs("mret_done", O_NONE);

    // wfi blocked by mem_busy
    next_cycle();
    wfi = 1; mem_busy = 1;
    expect_outs("wfi_busy", O_BUSY);
    next_cycle();
    wfi = 0; mem_busy = 0;
    expect_outs("wfi_busy_norun", O_NONE);

    // WFI sleep for cycles 1..10, interrupt pending in cycle 10
    next_cycle();
    wfi = 1;
    expect_outs("wfi_commit", O_NONE);
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      wfi = 0;
      if (k == 10) interrupt_pending = 1;
      expect_outs("sleep", O_SLEEP);
    end
    next_cycle();
    trap = 1;
    expect_outs("wake_trap", O_TRAP);
    next_cycle();
    clear_inputs();
    expect_outs("wake_flush", O_IF);
    for (int i = 0; i < 3; i++) next_cycle();
    expect_outs("wake_done", O_NONE);

    // wfi with interrupt already pending: one sleep cycle
    next_cycle();
    wfi = 1; interrupt_pending = 1;
    expect_outs("wfi_ip_commit", O_NONE);
    next_cycle();
    wfi = 0;
    expect_outs("wfi_ip_sleep", O_SLEEP);
    next_cycle();
    interrupt_pending = 0;
    expect_outs("wfi_ip_run", O_NONE);

    // Reset mid-sleep clears immediately
    next_cycle();
    wfi = 1;
    next_cycle();
    wfi = 0;
    expect_outs("pre_rst_sleep", O_SLEEP);
    reset_n = 0;
    expect_outs("rst_in_sleep", O_NONE);
    next_cycle();
    reset_n = 1;
    next_cycle();
    expect_outs("rst_sleep_run", O_NONE);

    // Reset mid-flush clears the counter
    branch_taken = 1;
    next_cycle();
    branch_taken = 0;
    expect_outs("pre_rst_flush", O_IF);
    reset_n = 0;
    expect_outs("rst_in_flush", O_NONE);
    next_cycle();
    reset_n = 1;
    expect_outs("rst_flush_clear", O_NONE);

    // RAW against memory then writeback producer
    next_cycle();
    mem_valid = 1; mem_rd_address = 5'd7; uses_rs2 = 1; rs2_address = 5'd7;
    expect_outs("raw_mem", O_RAW);
    next_cycle();
    mem_valid = 0; wb_valid = 1; wb_rd_address = 5'd7;
    expect_outs("raw_wb", O_RAW);
    next_cycle();
    wb_valid = 0;
    expect_outs("raw_clear", O_NONE);
    next_cycle();
    clear_inputs();
    ex_valid = 1; ex_load = 0; ex_rd_address = 5'd12; uses_rs1 = 1; rs1_address = 5'd12;
    expect_outs("raw_ex_alu", O_RAW);
    next_cycle();
    clear_inputs();
    wb_valid = 1; wb_rd_address = 5'd0; uses_rs1 = 1; rs1_address = 5'd0;
    expect_outs("raw_wb_x0", O_NONE);

    next_cycle();
    clear_inputs();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
- Central pipeline sequencer for the five-stage core (fetch, decode, execute, memory, writeback).
- Generates the per-stage stall and invalidate strobes, and detects load-use and RAW hazards from decode's uses_rs1/uses_rs2 and register addresses.
- Flushes younger stages on taken branches, traps and mret, and parks the pipeline in a sleep state for WFI until an interrupt is pending.
- Holds fetch invalidation for a programmable number of cycles after each redirect.

Parameters:
- REDIRECT_FLUSH, 1, cycles invalidate_fetch stays high after a redirect. Range 1..7; covers instruction-memory latency.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- uses_rs1  in  1  decode instruction reads rs1 (already qualified by decode valid)
- uses_rs2  in  1  decode instruction reads rs2
- rs1_address  in  5  decode rs1 index
- rs2_address  in  5  decode rs2 index
- ex_valid  in  1  execute stage holds a valid instruction
- ex_load  in  1  execute instruction is a load
- ex_rd_address  in  5  execute destination register
- mem_valid  in  1  memory stage holds a valid instruction
- mem_rd_address  in  5  memory destination register
- wb_valid  in  1  writeback stage holds a valid instruction
- wb_rd_address  in  5  writeback destination register
- branch_taken  in  1  execute resolved a taken branch or jump
- mem_busy  in  1  data memory has not completed the access
- trap  in  1  memory stage raises an exception or takes an interrupt
- mret  in  1  memory stage commits mret
- wfi  in  1  memory stage commits wfi
- interrupt_pending  in  1  an enabled interrupt is pending in the CSR unit
- stall_fetch, stall_decode, stall_execute, stall_memory  out  1 each  hold the stage register
- invalidate_fetch, invalidate_decode, invalidate_execute  out  1 each  squash the stage output
- sleeping  out  1  core is parked in WFI

Behaviour:
- Reset: state=RUN, flush counter=0. All stall and invalidate outputs are 0 and sleeping=0, asynchronously on reset_n low. Reset asserted mid-sleep or mid-flush returns to RUN immediately.
- All outputs are combinational from the current state, the counter and the inputs; only the state and counter are registered.
- Hazard match rule: a match requires rd != 0 and the producing stage valid. x0 never matches.
- Output priority per cycle, highest first:
  1. trap or mret: invalidate_fetch, invalidate_decode and invalidate_execute=1; no stalls; load counter with REDIRECT_FLUSH.
  2. mem_busy: all four stalls=1; no invalidates. A taken branch in execute is held and acted on in the first non-busy cycle.
  3. branch_taken: invalidate_fetch and invalidate_decode=1; load counter.
  4. Load-use (ex_load and an rs match with ex_rd_address): stall_fetch=1 and invalidate_decode=1 for exactly one cycle, inserting one bubble into execute.
  5. Otherwise: all outputs 0, except invalidate_fetch=1 while counter != 0.
- Counter: decrements by 1 each non-stalled cycle, saturates at 0, and is reloaded on every new redirect. A redirect arriving while the counter is non-zero restarts the count.
- State machine:
  - RUN -> SLEEP when wfi is high, mem_busy=0 and trap=0.
  - In SLEEP: stall_fetch, stall_decode and stall_execute=1; sleeping=1; invalidate_execute=1 so no instruction enters memory.
  - SLEEP -> RUN on interrupt_pending. The trap input then takes the interrupt, with the normal redirect flush in that same cycle.
  - wfi with interrupt_pending already high enters SLEEP for exactly one cycle.

Optional Feature:
- Macro: HAZARD_BYPASS_EN.
- Defined: execute, memory and writeback results are bypassed. Only the load-use hazard stalls, as above.
- Undefined: any rs match against ex_rd_address, mem_rd_address or wb_rd_address also applies the load-use response (stall_fetch plus invalidate_decode), repeating each cycle until no match remains.

Decomposition:
- Shared package: state encoding (RUN, SLEEP), the exported REDIRECT_FLUSH width, and the x0 constant.
- Sub-module hazard_match: combinational rs/rd comparator with x0 and valid qualification, instantiated per producing stage.

Test Plan:
- lw x5 in execute with decode uses_rs1, rs1=5 -> stall_fetch=1 and invalidate_decode=1 for 1 cycle; next cycle all outputs 0.
- Decode rs1=0, ex_load with rd=0 -> no stall.
- branch_taken with REDIRECT_FLUSH=3 -> invalidate_decode for 1 cycle, invalidate_fetch for 1+3 cycles. A second branch at cycle 2 reloads the counter to 3.
- mem_busy=1 for 4 cycles together with branch_taken -> all stalls for 4 cycles, then the flush on cycle 5. trap with mem_busy -> trap flush wins.
- wfi committed, interrupt_pending at cycle 10 -> sleeping=1 for cycles 1..10, then RUN. reset_n low at cycle 5 -> sleeping=0 immediately.
- Without HAZARD_BYPASS_EN: mem_rd=7 and decode rs2=7 with uses_rs2 -> stall until the producer leaves writeback (2 cycles).
